// File: rtl/si3000_sample_buffer.sv
// TX/RX sample FIFOs between the CPU/DMA side and the Si3000 codec wrapper.
// Optional watermark interrupt is built when SI3000_SAMPLE_BUF_IRQ_EN is defined.
module si3000_sample_buffer #(
  parameter int WORD_SIZE  = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int WATERMARK  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sync_reset,
  input  logic                  i_tx_wr,
  input  logic [WORD_SIZE-1:0]  i_tx_data,
  input  logic                  i_codec_grasp,
  output logic [WORD_SIZE-1:0]  o_write_data,
  input  logic                  i_codec_done,
  input  logic [WORD_SIZE-1:0]  i_codec_rd_data,
  input  logic                  i_rx_rd,
  output logic [WORD_SIZE-1:0]  o_rx_data,
  output logic [DEPTH_LOG2:0]   o_tx_count,
  output logic [DEPTH_LOG2:0]   o_rx_count,
  input  logic                  i_flag_clr,
  output logic                  o_tx_overflow,
  output logic                  o_tx_underrun,
  output logic                  o_rx_overflow,
  output logic                  o_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL = DEPTH_LOG2'(0) | (DEPTH_LOG2+1)'(DEPTH);

  logic [WORD_SIZE-1:0]  r_tx_mem [DEPTH];
  logic [WORD_SIZE-1:0]  r_rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [DEPTH_LOG2:0]   r_tx_cnt, r_rx_cnt;
  logic                  r_done_d1;
  logic                  r_tx_ovf, r_tx_udr, r_rx_ovf;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_edge;

  assign w_tx_full  = (r_tx_cnt == C_FULL);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == C_FULL);
  assign w_rx_empty = (r_rx_cnt == '0);

  assign w_rx_edge = i_codec_done & ~r_done_d1;
  assign w_tx_push = i_tx_wr & ~w_tx_full & ~i_sync_reset;
  assign w_tx_pop  = i_codec_grasp & ~w_tx_empty & ~i_sync_reset;
  assign w_rx_push = w_rx_edge & ~w_rx_full & ~i_sync_reset;
  assign w_rx_pop  = i_rx_rd & ~w_rx_empty & ~i_sync_reset;

  assign o_write_data = w_tx_empty ? '0 : r_tx_mem[r_tx_rp];
  assign o_rx_data    = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];
  assign o_tx_count   = r_tx_cnt;
  assign o_rx_count   = r_rx_cnt;
  assign o_tx_overflow = r_tx_ovf;
  assign o_tx_underrun = r_tx_udr;
  assign o_rx_overflow = r_rx_ovf;

  // Storage has no reset; the empty mux keeps the outputs at zero.
  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= i_tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= i_codec_rd_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else if (i_sync_reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Edge detector keeps running through sync_reset so a held done level
  // does not produce a second push once the flush is over.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_done_d1 <= 1'b0;
    else         r_done_d1 <= i_codec_done;
  end

  // Sticky flags: a set beats a same-cycle flag_clr.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_ovf <= 1'b0;
      r_tx_udr <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else if (i_sync_reset) begin
      r_tx_ovf <= 1'b0;
      r_tx_udr <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      r_tx_ovf <= (i_tx_wr & w_tx_full)         | (r_tx_ovf & ~i_flag_clr);
      r_tx_udr <= (i_codec_grasp & w_tx_empty)  | (r_tx_udr & ~i_flag_clr);
      r_rx_ovf <= (w_rx_edge & w_rx_full)       | (r_rx_ovf & ~i_flag_clr);
    end
  end

`ifdef SI3000_SAMPLE_BUF_IRQ_EN
  localparam logic [DEPTH_LOG2:0] C_WM = (DEPTH_LOG2+1)'(WATERMARK);
  logic r_irq;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_irq <= 1'b0;
    else         r_irq <= (r_rx_cnt >= C_WM) | (r_tx_cnt < C_WM)
                          | r_tx_ovf | r_tx_udr | r_rx_ovf;
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_si3000_sample_buffer.sv
// Directed self-checking bench for si3000_sample_buffer.
module tb_si3000_sample_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sync_reset = 1'b0;
  logic        tx_wr = 1'b0;
  logic [15:0] tx_data = '0;
  logic        codec_grasp = 1'b0;
  logic [15:0] write_data;
  logic        codec_done = 1'b0;
  logic [15:0] codec_rd_data = '0;
  logic        rx_rd = 1'b0;
  logic [15:0] rx_data;
  logic [4:0]  tx_count, rx_count;
  logic        flag_clr = 1'b0;
  logic        tx_overflow, tx_underrun, rx_overflow, irq;

  int n_tests = 0;
  int n_fail  = 0;

  si3000_sample_buffer dut (
    .i_clk(clk), .i_reset(reset), .i_sync_reset(sync_reset),
    .i_tx_wr(tx_wr), .i_tx_data(tx_data), .i_codec_grasp(codec_grasp),
    .o_write_data(write_data), .i_codec_done(codec_done),
    .i_codec_rd_data(codec_rd_data), .i_rx_rd(rx_rd), .o_rx_data(rx_data),
    .o_tx_count(tx_count), .o_rx_count(rx_count), .i_flag_clr(flag_clr),
    .o_tx_overflow(tx_overflow), .o_tx_underrun(tx_underrun),
    .o_rx_overflow(rx_overflow), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_push(input logic [15:0] d);
    tx_wr = 1'b1; tx_data = d;
    cyc();
    tx_wr = 1'b0;
  endtask

  task automatic rx_frame(input logic [15:0] d);
    codec_done = 1'b1; codec_rd_data = d;
    cyc();
    codec_done = 1'b0;
    cyc();
  endtask

  task automatic do_sync_reset();
    sync_reset = 1'b1;
    cyc();
    sync_reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    n_tests++;
    if (tx_count !== 5'd0 || rx_count !== 5'd0) begin
      n_fail++; $display("FAIL reset_counts: tx=%0d rx=%0d required 0/0", tx_count, rx_count);
    end
    n_tests++;
    if (write_data !== 16'h0 || rx_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_data: wd=%h rd=%h required 0000/0000", write_data, rx_data);
    end
    n_tests++;
    if ({tx_overflow, tx_underrun, rx_overflow, irq} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 0000",
                         {tx_overflow, tx_underrun, rx_overflow, irq});
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_tx_basic();
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
    tx_push(exp_w[0]);
    n_tests++;
    if (tx_count !== 5'd1 || write_data !== 16'h1111) begin
      n_fail++; $display("FAIL tx_first_latency: cnt=%0d wd=%h required 1/1111", tx_count, write_data);
    end
    for (int i = 1; i < 4; i++) tx_push(exp_w[i]);
    n_tests++;
    if (tx_count !== 5'd4) begin
      n_fail++; $display("FAIL tx_count_4: got %0d required 4", tx_count);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (write_data !== exp_w[i]) begin
        n_fail++; $display("FAIL tx_head_%0d: got %h required %h", i, write_data, exp_w[i]);
      end
      codec_grasp = 1'b1;
      cyc();
      codec_grasp = 1'b0;
      n_tests++;
      if (tx_count !== 5'(3 - i)) begin
        n_fail++; $display("FAIL tx_drain_cnt_%0d: got %0d required %0d", i, tx_count, 3 - i);
      end
    end
    n_tests++;
    if (write_data !== 16'h0000) begin
      n_fail++; $display("FAIL tx_empty_silence: got %h required 0000", write_data);
    end
  endtask

  task automatic test_underrun();
    codec_grasp = 1'b1;
    cyc();
    codec_grasp = 1'b0;
    n_tests++;
    if (tx_underrun !== 1'b1 || write_data !== 16'h0 || tx_count !== 5'd0) begin
      n_fail++; $display("FAIL underrun_set: udr=%b wd=%h cnt=%0d required 1/0000/0",
                         tx_underrun, write_data, tx_count);
    end
    flag_clr = 1'b1;
    cyc();
    flag_clr = 1'b0;
    n_tests++;
    if (tx_underrun !== 1'b0) begin
      n_fail++; $display("FAIL underrun_clr: got %b required 0", tx_underrun);
    end
    flag_clr = 1'b1; codec_grasp = 1'b1;
    cyc();
    flag_clr = 1'b0; codec_grasp = 1'b0;
    n_tests++;
    if (tx_underrun !== 1'b1) begin
      n_fail++; $display("FAIL underrun_set_wins: got %b required 1", tx_underrun);
    end
    // Empty FIFO: grasp is an underrun but the simultaneous write is kept.
    tx_wr = 1'b1; tx_data = 16'hBEEF; codec_grasp = 1'b1;
    cyc();
    tx_wr = 1'b0; codec_grasp = 1'b0;
    n_tests++;
    if (tx_count !== 5'd1 || write_data !== 16'hBEEF) begin
      n_fail++; $display("FAIL underrun_wr_kept: cnt=%0d wd=%h required 1/beef", tx_count, write_data);
    end
    do_sync_reset();
    n_tests++;
    if (tx_count !== 5'd0 || tx_underrun !== 1'b0) begin
      n_fail++; $display("FAIL sync_reset_tx: cnt=%0d udr=%b required 0/0", tx_count, tx_underrun);
    end
  endtask

  task automatic test_rx_overflow();
    for (int k = 1; k <= 17; k++) rx_frame(16'(k));
    n_tests++;
    if (rx_count !== 5'd16 || rx_overflow !== 1'b1) begin
      n_fail++; $display("FAIL rx_overflow: cnt=%0d ovf=%b required 16/1", rx_count, rx_overflow);
    end
    for (int k = 1; k <= 16; k++) begin
      n_tests++;
      if (rx_data !== 16'(k)) begin
        n_fail++; $display("FAIL rx_pop_%0d: got %h required %h", k, rx_data, 16'(k));
      end
      rx_rd = 1'b1;
      cyc();
      rx_rd = 1'b0;
    end
    n_tests++;
    if (rx_count !== 5'd0 || rx_data !== 16'h0) begin
      n_fail++; $display("FAIL rx_drained: cnt=%0d rd=%h required 0/0000", rx_count, rx_data);
    end
    rx_rd = 1'b1;
    cyc();
    rx_rd = 1'b0;
    n_tests++;
    if (rx_count !== 5'd0) begin
      n_fail++; $display("FAIL rx_rd_empty: cnt=%0d required 0", rx_count);
    end
    flag_clr = 1'b1;
    cyc();
    flag_clr = 1'b0;
    n_tests++;
    if (rx_overflow !== 1'b0) begin
      n_fail++; $display("FAIL rx_ovf_clr: got %b required 0", rx_overflow);
    end
  endtask

  task automatic test_done_held();
    codec_done = 1'b1; codec_rd_data = 16'hA5A5;
    repeat (5) cyc();
    codec_done = 1'b0;
    cyc();
    n_tests++;
    if (rx_count !== 5'd1 || rx_data !== 16'hA5A5) begin
      n_fail++; $display("FAIL done_held_once: cnt=%0d rd=%h required 1/a5a5", rx_count, rx_data);
    end
    rx_rd = 1'b1;
    cyc();
    rx_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) tx_push(16'h0100 + 16'(k));
    n_tests++;
    if (tx_count !== 5'd16 || tx_overflow !== 1'b0) begin
      n_fail++; $display("FAIL tx_full: cnt=%0d ovf=%b required 16/0", tx_count, tx_overflow);
    end
    tx_wr = 1'b1; tx_data = 16'hDEAD; codec_grasp = 1'b1;
    cyc();
    tx_wr = 1'b0; codec_grasp = 1'b0;
    n_tests++;
    if (tx_count !== 5'd15 || tx_overflow !== 1'b1 || write_data !== 16'h0101) begin
      n_fail++; $display("FAIL full_wr_grasp: cnt=%0d ovf=%b wd=%h required 15/1/0101",
                         tx_count, tx_overflow, write_data);
    end
    // Same-cycle push is discarded by the flush.
    sync_reset = 1'b1; tx_wr = 1'b1; tx_data = 16'h7777;
    cyc();
    sync_reset = 1'b0; tx_wr = 1'b0;
    n_tests++;
    if (tx_count !== 5'd0 || tx_overflow !== 1'b0 || write_data !== 16'h0) begin
      n_fail++; $display("FAIL sync_reset_discard: cnt=%0d ovf=%b wd=%h required 0/0/0000",
                         tx_count, tx_overflow, write_data);
    end
    tx_push(16'h0A0A); tx_push(16'h0B0B); tx_push(16'h0C0C);
    tx_wr = 1'b1; tx_data = 16'h0D0D; codec_grasp = 1'b1;
    cyc();
    tx_wr = 1'b0; codec_grasp = 1'b0;
    n_tests++;
    if (tx_count !== 5'd3 || write_data !== 16'h0B0B) begin
      n_fail++; $display("FAIL wr_grasp_3: cnt=%0d wd=%h required 3/0b0b", tx_count, write_data);
    end
    do_sync_reset();
  endtask

  task automatic test_irq();
`ifdef SI3000_SAMPLE_BUF_IRQ_EN
    for (int k = 0; k < 8; k++) tx_push(16'(k));
    for (int k = 0; k < 7; k++) rx_frame(16'(k));
    cyc();
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_quiet: got %b required 0", irq);
    end
    codec_done = 1'b1; codec_rd_data = 16'h0008;
    cyc();
    codec_done = 1'b0;
    n_tests++;
    if (rx_count !== 5'd8 || irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_lag: cnt=%0d irq=%b required 8/0", rx_count, irq);
    end
    cyc();
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_rx_wm: got %b required 1", irq);
    end
    do_sync_reset();
    cyc();
    n_tests++;
    if (tx_count !== 5'd0 || rx_count !== 5'd0 || irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_after_sync: tx=%0d rx=%0d irq=%b required 0/0/1",
                         tx_count, rx_count, irq);
    end
`else
    tx_push(16'h1);
    codec_grasp = 1'b1;
    cyc();
    codec_grasp = 1'b1;
    cyc();
    codec_grasp = 1'b0;
    n_tests++;
    if (tx_underrun !== 1'b1 || irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_tied_low: udr=%b irq=%b required 1/0", tx_underrun, irq);
    end
    do_sync_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_underrun();
    test_rx_overflow();
    test_done_held();
    test_back_to_back();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
